// File: rtl/pwm_compare.sv
// Registered PWM comparator fed by an up-counter; duty is staged via valid/ready and
// committed only at a period start. Optional sticky update IRQ under PWM_COMPARE_IRQ_EN.
module pwm_compare #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] q,
    input  logic [N:0]   duty,
    input  logic         duty_valid,
    output logic         duty_ready,
    output logic         pwm,
    output logic         period_start
`ifdef PWM_COMPARE_IRQ_EN
    ,
    output logic         irq,
    input  logic         irq_ack
`endif
);

    localparam logic [N:0] DUTY_FULL = {1'b1, {N{1'b0}}};

    logic [N:0]   active_q,       active_d;
    logic [N:0]   pending_q,      pending_d;
    logic         pending_flag_q, pending_flag_d;
    logic [N-1:0] q_prev_q,       q_prev_d;
    logic         first_q,        first_d;
    logic         pwm_q,          pwm_d;
    logic         period_start_q, period_start_d;

    logic         start;
    logic         commit;
    logic         xfer;
    logic [N:0]   duty_clamped;
    logic [N:0]   deff;

    // A period begins only when q arrives at 0 from a nonzero value (or right after reset).
    always_comb begin
        start        = (q == '0) && (first_q || (q_prev_q != '0));
        commit       = start && pending_flag_q;
        duty_ready   = !rst && !pending_flag_q;
        xfer         = duty_valid && duty_ready;
        duty_clamped = (duty > DUTY_FULL) ? DUTY_FULL : duty;
        deff         = commit ? pending_q : active_q;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_flag_d = pending_flag_q;
        if (commit) begin
            active_d       = pending_q;
            pending_flag_d = 1'b0;
        end else if (xfer) begin
            // ready is low whenever a commit is possible, so these never coincide
            pending_d      = duty_clamped;
            pending_flag_d = 1'b1;
        end
        q_prev_d       = q;
        first_d        = 1'b0;
        pwm_d          = ({1'b0, q} < deff);
        period_start_d = start;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: pending_q is reset too, although pending_flag_q alone already marks it invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_flag_q <= 1'b0;
            q_prev_q       <= '0;
            first_q        <= 1'b1;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_flag_q <= pending_flag_d;
            q_prev_q       <= q_prev_d;
            first_q        <= first_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = period_start_q;

`ifdef PWM_COMPARE_IRQ_EN
    logic irq_q, irq_d;

    // A commit in the same cycle as an ack keeps the flag set.
    always_comb begin
        irq_d = irq_q;
        if (commit)       irq_d = 1'b1;
        else if (irq_ack) irq_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Directed self-checking bench for pwm_compare (N=3) with a free-running 0..7 counter.
// Optional IRQ checks are compiled in when PWM_COMPARE_IRQ_EN is defined.
module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q = '0;
    logic [3:0] duty = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic       pwm;
    logic       period_start;
    logic       irq_ack = 1'b0;
`ifdef PWM_COMPARE_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;

    logic       ready_pre;
    logic       pend = 1'b0;
    logic       offering = 1'b0;
    logic [3:0] off_d = '0;

    always #5 clk = ~clk;

    pwm_compare #(.N(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .q            (q),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm          (pwm),
        .period_start (period_start)
`ifdef PWM_COMPARE_IRQ_EN
        ,
        .irq          (irq),
        .irq_ack      (irq_ack)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one counter value at the negedge, capture ready before the edge,
    // return at the next negedge with the registered outputs for that q.
    task automatic step(input logic [2:0] qv, input logic v, input logic [3:0] d);
        q          = qv;
        duty_valid = v;
        duty       = d;
        #1;
        ready_pre = duty_ready;
        @(posedge clk);
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    // One full period q=0..7; exp_duty is the duty expected to be active for this whole
    // period. Offers start at o1q/o2q and are held until accepted.
    task automatic run_period(input int exp_duty, input int o1q, input logic [3:0] d1,
                              input int o2q, input logic [3:0] d2, input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i == o1q) begin offering = 1'b1; off_d = d1; end
            if (i == o2q) begin offering = 1'b1; off_d = d2; end
            step(3'(i), offering, off_d);
            check($sformatf("%s rdy q=%0d", tag, i), 32'(ready_pre), 32'(!pend));
            if (i == 0 && pend) pend = 1'b0;
            else if (offering && !pend) begin pend = 1'b1; offering = 1'b0; end
            check($sformatf("%s pwm q=%0d", tag, i), 32'(pwm), 32'(i < exp_duty));
            check($sformatf("%s ps q=%0d", tag, i), 32'(period_start), 32'(i == 0));
        end
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        step(3'd0, 1'b0, 4'd0);
        step(3'd0, 1'b1, 4'd5);
        check("reset ready", 32'(ready_pre), 32'd0);
        check("reset pwm", 32'(pwm), 32'd0);
        check("reset ps", 32'(period_start), 32'd0);
`ifdef PWM_COMPARE_IRQ_EN
        check("reset irq", 32'(irq), 32'd0);
`endif
        rst = 1'b0;

        run_period(0, -1, 4'd0, -1, 4'd0, "idle0");
        run_period(0, -1, 4'd0, -1, 4'd0, "idle1");
        run_period(0,  3, 4'd3, -1, 4'd0, "wr3");
        run_period(3,  2, 4'd0, -1, 4'd0, "d3");
        run_period(0,  2, 4'd8, -1, 4'd0, "d0");
        run_period(8,  2, 4'd15, -1, 4'd0, "d8");
        run_period(8, -1, 4'd0, -1, 4'd0, "d15clamp");
        run_period(8,  0, 4'd5, -1, 4'd0, "offer_at_q0");
        run_period(5,  3, 4'd6,  5, 4'd2, "d5_hold");
        run_period(6, -1, 4'd0, -1, 4'd0, "d6");
        run_period(2,  2, 4'd7, -1, 4'd0, "d2");
        run_period(7, -1, 4'd0, -1, 4'd0, "d7");

        // Reset mid-period with duty 4 staged; the staged value must be discarded.
        step(3'd0, 1'b0, 4'd0);
        check("mid q0 pwm", 32'(pwm), 32'd1);
        step(3'd1, 1'b1, 4'd4);
        check("mid offer rdy", 32'(ready_pre), 32'd1);
        step(3'd2, 1'b0, 4'd0);
        check("mid pend rdy", 32'(ready_pre), 32'd0);
        rst = 1'b1;
        step(3'd3, 1'b0, 4'd0);
        check("mid rst rdy", 32'(ready_pre), 32'd0);
        check("mid rst pwm", 32'(pwm), 32'd0);
        check("mid rst ps", 32'(period_start), 32'd0);
        rst  = 1'b0;
        pend = 1'b0;
        for (int i = 4; i < 8; i++) begin
            step(3'(i), 1'b0, 4'd0);
            check($sformatf("post rst rdy q=%0d", i), 32'(ready_pre), 32'd1);
            check($sformatf("post rst pwm q=%0d", i), 32'(pwm), 32'd0);
            check($sformatf("post rst ps q=%0d", i), 32'(period_start), 32'd0);
        end
`ifdef PWM_COMPARE_IRQ_EN
        check("post rst irq", 32'(irq), 32'd0);
`endif
        run_period(0,  2, 4'd1, -1, 4'd0, "after_rst");
`ifdef PWM_COMPARE_IRQ_EN
        check("irq before commit", 32'(irq), 32'd0);
`endif
        run_period(1, -1, 4'd0, -1, 4'd0, "d1");
`ifdef PWM_COMPARE_IRQ_EN
        check("irq sticky", 32'(irq), 32'd1);
        irq_ack = 1'b1;
        step(3'd0, 1'b0, 4'd0);
        irq_ack = 1'b0;
        check("irq ack", 32'(irq), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
